iir_out_buffer: RTL and testbench

//  Output-side elastic buffer placed directly downstream of IIR_filter. Captures each

---
 rtl/iir_pkg.sv | 18 +
 rtl/fifo_regfile.sv | 25 ++
 rtl/iir_out_buffer.sv | 77 +++++++
 tb/tb_iir_out_buffer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter datapath and its output-side buffering.
package iir_pkg;

    localparam int NB_DEF = 10;

    typedef logic signed [NB_DEF-1:0] sample_t;

    // Ceiling log2; stands in for $clog2 on older toolchains.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x NB register array: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
    parameter int NB    = 10,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [NB-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [NB-1:0] rdata
);

    logic [NB-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/iir_out_buffer.sv
// First-word-fall-through elastic buffer behind IIR_filter; the filter cannot be
// stalled, so samples arriving while full are dropped and flagged on sticky OVF.
module iir_out_buffer
    import iir_pkg::*;
#(
    parameter int   NB    = NB_DEF,
    parameter int   DEPTH = 8,
    localparam int  AW    = clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic [NB-1:0] DIN,
    input  logic          VIN,
    output logic [NB-1:0] DOUT,
    output logic          VOUT,
    input  logic          RDY_IN,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   COUNT,
    output logic          OVF
);

    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [NB-1:0] rd_data;

    assign EMPTY = (COUNT == '0);
    assign FULL  = (COUNT == CNT_FULL);
    assign VOUT  = ~EMPTY;
    assign pop   = VOUT & RDY_IN;
    // A pop frees a slot in the same cycle, so a push at full is still accepted.
    assign push  = VIN & (~FULL | pop);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
            OVF    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                COUNT <= COUNT + 1'b1;
            end else if (pop && !push) begin
                COUNT <= COUNT - 1'b1;
            end
            if (VIN && !push) begin
                OVF <= 1'b1;
            end
        end
    end

    fifo_regfile #(
        .NB    (NB),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (CLK),
        .we    (push & RST_n),
        .waddr (wr_ptr),
        .wdata (DIN),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign DOUT = VOUT ? rd_data : '0;

endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed vector table plus a scoreboarded streaming sequence for iir_out_buffer.
module tb_iir_out_buffer;

    logic       CLK;
    logic       RST_n;
    logic [9:0] DIN;
    logic       VIN;
    logic [9:0] DOUT;
    logic       VOUT;
    logic       RDY_IN;
    logic       FULL;
    logic       EMPTY;
    logic [3:0] COUNT;
    logic       OVF;

    iir_out_buffer #(
        .NB    (10),
        .DEPTH (8)
    ) dut (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .DIN    (DIN),
        .VIN    (VIN),
        .DOUT   (DOUT),
        .VOUT   (VOUT),
        .RDY_IN (RDY_IN),
        .FULL   (FULL),
        .EMPTY  (EMPTY),
        .COUNT  (COUNT),
        .OVF    (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic       vin;
        logic [9:0] din;
        logic       rdy;
        int         cnt;
        logic       vout;
        logic [9:0] dout;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(input int rst_n, input int vin, input int din, input int rdy,
                                input int cnt, input int vout, input int dout, input int ovf);
        vec_t v;
        v.rst_n = (rst_n != 0);
        v.vin   = (vin != 0);
        v.din   = din[9:0];
        v.rdy   = (rdy != 0);
        v.cnt   = cnt;
        v.vout  = (vout != 0);
        v.dout  = dout[9:0];
        v.ovf   = (ovf != 0);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [9:0] q[$];
        int sent;
        int popped;
        int drops;
        logic pop_m;
        logic push_m;

        n_cmp = 0;
        n_bad = 0;

        // Reset held with VIN active
        add(0, 1, 'h155, 0, 0, 0, 0, 0);
        add(0, 1, 'h155, 0, 0, 0, 0, 0);
        // Pass-through, one cycle each
        add(1, 1, 'h2D1, 1, 1, 1, 'h2D1, 0);
        add(1, 0, 0,     1, 0, 0, 0,     0);
        add(1, 1, 445,   1, 1, 1, 445,   0);
        add(1, 0, 0,     1, 0, 0, 0,     0);
        // Fill, overflow, drain
        for (int k = 1; k <= 8; k++) add(1, 1, k, 0, k, 1, 1, 0);
        add(1, 1, 9, 0, 8, 1, 1, 1);
        for (int k = 1; k <= 8; k++) add(1, 0, 0, 1, 8 - k, (k < 8) ? 1 : 0, (k < 8) ? k + 1 : 0, 1);
        // Push+pop at full
        add(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(1, 1, 10 + k, 0, k, 1, 11, 0);
        add(1, 1, 100, 1, 8, 1, 12, 0);
        for (int k = 1; k <= 8; k++)
            add(1, 0, 0, 1, 8 - k, (k < 8) ? 1 : 0, (k <= 6) ? 12 + k : ((k == 7) ? 100 : 0), 0);
        // Reset mid-operation with COUNT=5, OVF=1
        for (int k = 1; k <= 8; k++) add(1, 1, 20 + k, 0, k, 1, 21, 0);
        add(1, 1, 29, 0, 8, 1, 21, 1);
        for (int k = 1; k <= 3; k++) add(1, 0, 0, 1, 8 - k, 1, 21 + k, 1);
        add(0, 1, 'h3FF, 1, 0, 0, 0, 0);
        add(1, 1, 7, 0, 1, 1, 7, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            RST_n  = vecs[i].rst_n;
            VIN    = vecs[i].vin;
            DIN    = vecs[i].din;
            RDY_IN = vecs[i].rdy;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d.count", i), 32'(COUNT), 32'(vecs[i].cnt));
            chk($sformatf("v%0d.vout", i),  32'(VOUT),  32'(vecs[i].vout));
            chk($sformatf("v%0d.dout", i),  32'(DOUT),  32'(vecs[i].dout));
            chk($sformatf("v%0d.full", i),  32'(FULL),  32'(vecs[i].cnt == 8));
            chk($sformatf("v%0d.empty", i), 32'(EMPTY), 32'(vecs[i].cnt == 0));
            chk($sformatf("v%0d.ovf", i),   32'(OVF),   32'(vecs[i].ovf));
        end

        // Streaming with toggling ready: 20 samples through 8 entries wraps pointers twice
        sent   = 0;
        popped = 0;
        drops  = 0;
        RST_n  = 1'b1;
        for (int c = 0; c < 200 && (sent < 20 || q.size() > 0); c++) begin
            VIN    = (sent < 20) && (c % 3 != 2);
            DIN    = 10'(200 + sent);
            RDY_IN = (c % 2 == 0);
            chk($sformatf("s%0d.vout", c), 32'(VOUT), 32'(q.size() > 0));
            pop_m = RDY_IN && (q.size() > 0);
            if (pop_m) begin
                chk($sformatf("s%0d.dout", c), 32'(DOUT), 32'(q[0]));
            end
            push_m = VIN && ((q.size() < 8) || pop_m);
            if (VIN && !push_m) drops++;
            @(posedge CLK);
            #1;
            if (pop_m) begin
                void'(q.pop_front());
                popped++;
            end
            if (push_m) q.push_back(10'(200 + sent));
            if (VIN) sent++;
            chk($sformatf("s%0d.count", c), 32'(COUNT), 32'(q.size()));
            chk($sformatf("s%0d.ovf", c), 32'(OVF), 32'(drops > 0));
        end
        VIN    = 1'b0;
        RDY_IN = 1'b0;
        chk("stream.popped", 32'(popped), 32'd20);
        chk("stream.drained", 32'(q.size()), 32'd0);
        chk("stream.empty", 32'(EMPTY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
